fetch_stage: RTL



---
 rtl/fetch_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues in-order instruction-memory reads and feeds decode.
// Optional stall-cycle counter output is enabled by defining FETCH_STALL_COUNTER_EN.

package pipeline_status;
  typedef enum logic [1:0] {
    READY = 2'd0,
    STALL = 2'd1,
    JUMP  = 2'd2
  } backwards_t;

  typedef enum logic {
    VALID  = 1'b0,
    BUBBLE = 1'b1
  } forwards_t;
endpackage

module fetch_stage
  import pipeline_status::*;
#(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int unsigned BUFFER_DEPTH = 2,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
`ifdef FETCH_STALL_COUNTER_EN
  output logic [31:0]                 stall_cycles_out,
`endif
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid_out,
  input  logic                        imem_req_ready_in,
  output logic [31:0]                 imem_addr_out,
  input  logic                        imem_rsp_valid_in,
  input  logic [31:0]                 imem_rsp_data_in,
  output logic [31:0]                 instruction_reg_out,
  output logic [31:0]                 program_counter_reg_out,
  output pipeline_status::forwards_t  status_forwards_out,
  input  pipeline_status::backwards_t status_backwards_in,
  input  logic [31:0]                 jump_address_backwards_in
);

  localparam int unsigned PTR_W  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = PTR_W + 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  logic [31:0]       pc_r;
  logic [31:0]       buf_pc_r   [BUFFER_DEPTH];
  logic [31:0]       buf_data_r [BUFFER_DEPTH];
  logic [PTR_W-1:0]  head_r, tail_r, fill_r;
  logic [CNT_W-1:0]  used_r, unfilled_r;
  logic [DROP_W-1:0] drop_cnt_r;
  logic [31:0]       instr_r, pc_out_r;
  forwards_t         status_r;

  logic              is_ready_s, is_stall_s, is_jump_s;
  logic              req_valid_s, req_fire_s;
  logic              rsp_drop_s, rsp_fill_s;
  logic              head_filled_s, bypass_s, pop_s;
  logic [31:0]       pop_data_s, pop_pc_s;
  logic [DROP_W-1:0] jump_drop_s;

  // Decode the backwards status; an unknown encoding is treated as a stall (hold).
  always_comb begin
    is_ready_s = 1'b0;
    is_stall_s = 1'b0;
    is_jump_s  = 1'b0;
    case (status_backwards_in)
      READY:   is_ready_s = 1'b1;
      STALL:   is_stall_s = 1'b1;
      JUMP:    is_jump_s  = 1'b1;
      default: is_stall_s = 1'b1;
    endcase
  end

  // Request, response and pop decisions for this cycle.
  always_comb begin
    req_valid_s   = (used_r < DEPTH_C);
    req_fire_s    = req_valid_s & imem_req_ready_in;
    rsp_drop_s    = imem_rsp_valid_in & (drop_cnt_r != {DROP_W{1'b0}});
    rsp_fill_s    = imem_rsp_valid_in & (drop_cnt_r == {DROP_W{1'b0}}) &
                    (unfilled_r != {CNT_W{1'b0}});
    // Entries fill in order, so the head is filled whenever any entry is.
    head_filled_s = (used_r != unfilled_r);
    bypass_s      = rsp_fill_s & ~head_filled_s;
    pop_s         = is_ready_s & (head_filled_s | bypass_s);
    pop_pc_s      = buf_pc_r[head_r];
    if (head_filled_s) begin
      pop_data_s = buf_data_r[head_r];
    end else begin
      pop_data_s = imem_rsp_data_in;
    end
    // Every response still owed after a jump must be discarded; one arriving now is already spent.
    jump_drop_s = drop_cnt_r + DROP_W'(unfilled_r) + DROP_W'(req_fire_s)
                  - DROP_W'(imem_rsp_valid_in);
  end

  // PC, buffer pointers, occupancy and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= RESET_ADDR;
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      fill_r     <= {PTR_W{1'b0}};
      used_r     <= {CNT_W{1'b0}};
      unfilled_r <= {CNT_W{1'b0}};
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (is_jump_s) begin
      pc_r       <= jump_address_backwards_in;
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      fill_r     <= {PTR_W{1'b0}};
      used_r     <= {CNT_W{1'b0}};
      unfilled_r <= {CNT_W{1'b0}};
      drop_cnt_r <= jump_drop_s;
    end else begin
      if (req_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
        pc_r   <= pc_r + 32'd4;
      end
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - DROP_W'(1'b1);
      end
      if (rsp_fill_s) begin
        fill_r <= fill_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      used_r     <= used_r + CNT_W'(req_fire_s) - CNT_W'(pop_s);
      unfilled_r <= unfilled_r + CNT_W'(req_fire_s) - CNT_W'(rsp_fill_s);
    end
  end

  // Buffer storage: PC written at request accept, data written at response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        buf_pc_r[i]   <= 32'h0000_0000;
        buf_data_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (req_fire_s && !is_jump_s) begin
        buf_pc_r[tail_r] <= pc_r;
      end
      if (rsp_fill_s && !is_jump_s) begin
        buf_data_r[fill_r] <= imem_rsp_data_in;
      end
    end
  end

  // Decode-facing output registers: jump flushes, ready advances, stall holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_r  <= NOP_INSN;
      pc_out_r <= RESET_ADDR;
      status_r <= BUBBLE;
    end else if (is_jump_s) begin
      instr_r  <= NOP_INSN;
      status_r <= BUBBLE;
    end else if (!is_stall_s) begin
      if (pop_s) begin
        instr_r  <= pop_data_s;
        pc_out_r <= pop_pc_s;
        status_r <= VALID;
      end else begin
        instr_r  <= NOP_INSN;
        status_r <= BUBBLE;
      end
    end
  end

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stall cycles and empty-buffer bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if ((is_stall_s || (is_ready_s && !pop_s)) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cycles_out = stall_cnt_r;
`endif

  assign imem_req_valid_out      = req_valid_s;
  assign imem_addr_out           = pc_r;
  assign instruction_reg_out     = instr_r;
  assign program_counter_reg_out = pc_out_r;
  assign status_forwards_out     = status_r;

endmodule
